// File: rtl/ysyx_23060208_ifu_prefetch_if.sv
// Fetch-side bundle: EXU redirect, isram AR/R read channel and the IFU->IDU instruction queue head.
// master = fetch unit, slave = surrounding environment (EXU, isram, IDU).
interface ysyx_23060208_ifu_prefetch_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;

    logic [ADDR_WIDTH-1:0] isram_araddr;
    logic                  isram_arvalid;
    logic                  isram_arready;
    logic [DATA_WIDTH-1:0] isram_rdata;
    logic                  isram_rvalid;
    logic [1:0]            isram_rresp;
    logic                  isram_rready;

    logic                  ifu_to_idu_valid;
    logic [ADDR_WIDTH-1:0] ifu_to_idu_pc;
    logic [DATA_WIDTH-1:0] ifu_to_idu_inst;
    logic                  ifu_to_idu_err;
    logic                  idu_allowin;
    logic [CNT_W-1:0]      fifo_count;

    modport master (
        input  redirect_valid, redirect_pc,
        input  isram_arready, isram_rdata, isram_rvalid, isram_rresp,
        input  idu_allowin,
        output isram_araddr, isram_arvalid, isram_rready,
        output ifu_to_idu_valid, ifu_to_idu_pc, ifu_to_idu_inst, ifu_to_idu_err, fifo_count
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output isram_arready, isram_rdata, isram_rvalid, isram_rresp,
        output idu_allowin,
        input  isram_araddr, isram_arvalid, isram_rready,
        input  ifu_to_idu_valid, ifu_to_idu_pc, ifu_to_idu_inst, ifu_to_idu_err, fifo_count
    );
endinterface

// File: rtl/ysyx_23060208_ifu_prefetch.sv
// Sequential instruction prefetcher: keeps up to MAX_OUTSTANDING isram reads in flight and
// buffers returned instructions with their PC in a FIFO_DEPTH-entry queue for IDU.
module ysyx_23060208_ifu_prefetch #(
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = 32'h8000_0000,
    parameter int unsigned           FIFO_DEPTH      = 4,
    parameter int unsigned           MAX_OUTSTANDING = 2
) (
    input logic                          clk,
    input logic                          rst,
    ysyx_23060208_ifu_prefetch_if.master bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0]      DEPTH_S   = SUM_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]      MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(4);

    logic                  arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic                  rready_q;
    logic                  stale_ar_q, stale_ar_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [CNT_W-1:0]      discard_q, discard_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;

    logic [ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] inst_mem [FIFO_DEPTH];
    logic                  err_mem  [FIFO_DEPTH];

    logic                  ar_hs, r_hs, push, pop, issue, redirect;
    logic [CNT_W-1:0]      out_issue;
    logic [SUM_W-1:0]      occ_issue;

    always_comb begin
        redirect  = bus.redirect_valid;
        ar_hs     = arvalid_q & bus.isram_arready;
        r_hs      = bus.isram_rvalid & rready_q;
        push      = r_hs & ~redirect & (discard_q == '0);
        pop       = (count_q != '0) & bus.idu_allowin & ~redirect;
        // Space is reserved at issue: in-flight reads plus queued entries never exceed the queue.
        out_issue = outstanding_q + CNT_W'(ar_hs);
        occ_issue = SUM_W'(out_issue) + SUM_W'(count_q);
        issue     = (~arvalid_q | ar_hs) & ~redirect &
                    (out_issue < MAX_OUT_C) & (occ_issue < DEPTH_S);

        outstanding_d = out_issue - CNT_W'(r_hs);
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        stale_ar_d    = stale_ar_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (ar_hs) begin
            stale_ar_d = 1'b0;
            // A request that was pending across a redirect must not advance the new stream.
            if (!stale_ar_q) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
        end

        if (redirect) begin
            fetch_pc_d = bus.redirect_pc;
            resp_pc_d  = bus.redirect_pc;
            // Everything still in flight is stale, including a request not yet accepted.
            discard_d  = outstanding_d + CNT_W'(arvalid_q & ~ar_hs);
            stale_ar_d = arvalid_q & ~ar_hs;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (r_hs && (discard_q != '0)) begin
                discard_d = discard_q - CNT_W'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + PC_STEP;
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        if (issue) begin
            arvalid_d = 1'b1;
            araddr_d  = fetch_pc_d;
        end else if (ar_hs) begin
            arvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arvalid_q     <= 1'b0;
            araddr_q      <= RESET_PC;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            rready_q      <= 1'b0;
            stale_ar_q    <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            arvalid_q     <= arvalid_d;
            araddr_q      <= araddr_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            rready_q      <= 1'b1;
            stale_ar_q    <= stale_ar_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= resp_pc_q;
            inst_mem[wr_ptr_q] <= bus.isram_rdata;
            err_mem[wr_ptr_q]  <= bus.isram_rresp != 2'b00;
        end
    end

    assign bus.isram_arvalid    = arvalid_q;
    assign bus.isram_araddr     = araddr_q;
    assign bus.isram_rready     = rready_q;
    assign bus.fifo_count       = count_q;
    assign bus.ifu_to_idu_valid = count_q != '0;
    // Head fields read as zero while empty so stale entries never leak out.
    assign bus.ifu_to_idu_pc    = (count_q != '0) ? pc_mem[rd_ptr_q] : '0;
    assign bus.ifu_to_idu_inst  = (count_q != '0) ? inst_mem[rd_ptr_q] : '0;
    assign bus.ifu_to_idu_err   = (count_q != '0) ? err_mem[rd_ptr_q] : 1'b0;
endmodule

// File: tb/tb_ysyx_23060208_ifu_prefetch.sv
// Randomised bench for the prefetcher: a transaction-level memory/IDU model tracks which fetches
// must reach IDU (address order, data, error flag) and which are stale after a redirect.
module tb_ysyx_23060208_ifu_prefetch;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned MAXO   = 2;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ysyx_23060208_ifu_prefetch_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(DEPTH)) bus ();

    ysyx_23060208_ifu_prefetch #(
        .DATA_WIDTH      (32),
        .ADDR_WIDTH      (32),
        .RESET_PC        (RST_PC),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        bit          keep;
        int          ready_at;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } ent_t;

    req_t        acc[$];    // accepted reads awaiting response, in order
    ent_t        exp_q[$];  // what IDU must see, in order
    logic [31:0] exp_fetch;
    bit          ar_stale;
    int          cyc;
    int          n_cmp;
    int          n_bad;

    int          p_arready, p_allowin, p_redirect, p_err, max_delay;
    bit          hold_r;
    logic [31:0] err_addr;

    bit          prev_pending, prev_must_issue, prev_redirect, first_cycle;
    logic [31:0] prev_addr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_idle();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.isram_arready  = 1'b0;
        bus.isram_rdata    = '0;
        bus.isram_rvalid   = 1'b0;
        bus.isram_rresp    = 2'b00;
        bus.idu_allowin    = 1'b0;
    endtask

    task automatic model_reset();
        acc.delete();
        exp_q.delete();
        exp_fetch       = RST_PC;
        ar_stale        = 1'b0;
        prev_pending    = 1'b0;
        prev_must_issue = 1'b0;
        prev_redirect   = 1'b0;
        first_cycle     = 1'b1;
    endtask

    // Assert rst asynchronously mid-cycle; outputs must return to reset values before any edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        drive_idle();
        #1;
        check("rst_arvalid", 64'(bus.isram_arvalid), 64'(0));
        check("rst_araddr", 64'(bus.isram_araddr), 64'(RST_PC));
        check("rst_rready", 64'(bus.isram_rready), 64'(0));
        check("rst_valid", 64'(bus.ifu_to_idu_valid), 64'(0));
        check("rst_pc", 64'(bus.ifu_to_idu_pc), 64'(0));
        check("rst_inst", 64'(bus.ifu_to_idu_inst), 64'(0));
        check("rst_err", 64'(bus.ifu_to_idu_err), 64'(0));
        check("rst_count", 64'(bus.fifo_count), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One cycle: check outputs, choose inputs, advance the model, move to the next negedge.
    task automatic step(input bit force_redirect, input logic [31:0] force_pc);
        logic        arv;
        logic [31:0] ara;
        logic [31:0] rpc;
        bit          ar_hs, r_hs, pop, redir;
        int          out_before;
        req_t        e;

        arv = bus.isram_arvalid;
        ara = bus.isram_araddr;

        check("fifo_count", 64'(bus.fifo_count), 64'(exp_q.size()));
        check("idu_valid", 64'(bus.ifu_to_idu_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("idu_pc", 64'(bus.ifu_to_idu_pc), 64'(exp_q[0].pc));
            check("idu_inst", 64'(bus.ifu_to_idu_inst), 64'(exp_q[0].inst));
            check("idu_err", 64'(bus.ifu_to_idu_err), 64'(exp_q[0].err));
        end
        check("rready", 64'(bus.isram_rready), 64'(!first_cycle));
        if (prev_pending) begin
            check("ar_hold_valid", 64'(arv), 64'(1));
            check("ar_hold_addr", 64'(ara), 64'(prev_addr));
        end
        if (prev_must_issue) check("ar_issue", 64'(arv), 64'(1));
        if (prev_redirect && !prev_pending) check("no_issue_at_redirect", 64'(arv), 64'(0));
        check("max_outstanding", 64'(acc.size() <= MAXO), 64'(1));
        check("occupancy", 64'(acc.size() + int'(bus.fifo_count) <= DEPTH), 64'(1));

        redir = force_redirect || ($urandom_range(99) < p_redirect);
        if (force_redirect) rpc = force_pc;
        else if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF8;
        else rpc = $urandom() & 32'hFFFF_FFFC;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.isram_arready  = $urandom_range(99) < p_arready;
        bus.idu_allowin    = $urandom_range(99) < p_allowin;
        if (acc.size() != 0 && acc[0].ready_at <= cyc && !hold_r) begin
            bus.isram_rvalid = 1'b1;
            bus.isram_rdata  = acc[0].data;
            bus.isram_rresp  = acc[0].resp;
        end else begin
            bus.isram_rvalid = 1'b0;
            bus.isram_rdata  = $urandom();
            bus.isram_rresp  = 2'b00;
        end

        ar_hs      = arv && bus.isram_arready;
        r_hs       = bus.isram_rvalid && bus.isram_rready;
        pop        = (exp_q.size() != 0) && bus.idu_allowin && !redir;
        out_before = acc.size();
        prev_must_issue = (!arv || ar_hs) && !redir && (out_before + int'(ar_hs) < MAXO) &&
                          (out_before + int'(ar_hs) + exp_q.size() < DEPTH);

        if (r_hs) e = acc.pop_front();
        if (ar_hs) begin
            if (!ar_stale) begin
                check("araddr", 64'(ara), 64'(exp_fetch));
                exp_fetch = exp_fetch + 32'd4;
            end
            acc.push_back('{addr: ara, data: $urandom(),
                            resp: (ara == err_addr || $urandom_range(99) < p_err) ?
                                  2'($urandom_range(3, 1)) : 2'b00,
                            keep: !ar_stale && !redir,
                            ready_at: cyc + 1 + int'($urandom_range(max_delay))});
            ar_stale = 1'b0;
        end
        if (redir) begin
            foreach (acc[i]) acc[i].keep = 1'b0;
            if (arv && !ar_hs) ar_stale = 1'b1;
            exp_fetch = rpc;
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (r_hs && e.keep) exp_q.push_back('{pc: e.addr, inst: e.data, err: e.resp != 2'b00});
        end

        prev_pending  = arv && !ar_hs;
        prev_addr     = ara;
        prev_redirect = redir;
        first_cycle   = 1'b0;
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_knobs(input int ar, input int al, input int rd, input int er, input int dl);
        p_arready  = ar;
        p_allowin  = al;
        p_redirect = rd;
        p_err      = er;
        max_delay  = dl;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit hit;
        n_cmp    = 0;
        n_bad    = 0;
        cyc      = 0;
        hold_r   = 1'b0;
        err_addr = 32'h1;
        drive_idle();
        model_reset();
        @(negedge clk);

        // Streaming with single-cycle memory latency.
        do_reset();
        set_knobs(100, 100, 0, 0, 0);
        repeat (30) step(1'b0, '0);

        // IDU stalled: queue fills to depth, fetch stops, then resumes at the next PC.
        do_reset();
        set_knobs(100, 0, 0, 0, 0);
        repeat (20) step(1'b0, '0);
        check("t2_count_full", 64'(bus.fifo_count), 64'(4));
        check("t2_arvalid_idle", 64'(bus.isram_arvalid), 64'(0));
        p_allowin = 100;
        hit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.isram_arvalid) begin
                hit = 1'b1;
                break;
            end
            step(1'b0, '0);
        end
        check("t2_resume_seen", 64'(hit), 64'(1));
        check("t2_resume_addr", 64'(bus.isram_araddr), 64'(32'h8000_0010));
        repeat (10) step(1'b0, '0);

        // Back-pressure on AR: request must hold steady.
        do_reset();
        set_knobs(0, 100, 0, 0, 0);
        step(1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", 64'(bus.isram_arvalid), 64'(1));
            check("t3_hold_addr", 64'(bus.isram_araddr), 64'(RST_PC));
            step(1'b0, '0);
        end
        p_arready = 100;
        repeat (10) step(1'b0, '0);

        // Redirect with two reads in flight.
        do_reset();
        set_knobs(100, 100, 0, 0, 0);
        hold_r = 1'b1;
        hit    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (acc.size() == 2) begin
                hit = 1'b1;
                break;
            end
            step(1'b0, '0);
        end
        check("t4_two_in_flight", 64'(hit), 64'(1));
        step(1'b1, 32'h8000_0100);
        hold_r = 1'b0;
        hit    = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.ifu_to_idu_valid) begin
                hit = 1'b1;
                break;
            end
            step(1'b0, '0);
        end
        check("t4_head_seen", 64'(hit), 64'(1));
        check("t4_first_pc", 64'(bus.ifu_to_idu_pc), 64'(32'h8000_0100));
        repeat (10) step(1'b0, '0);

        // Redirect colliding with an R handshake and a pop while three entries are queued.
        do_reset();
        set_knobs(100, 0, 0, 0, 0);
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.fifo_count == 3 && acc.size() != 0 && acc[0].ready_at <= cyc) begin
                p_allowin = 100;
                step(1'b1, 32'h8000_0200);
                hit = 1'b1;
                break;
            end
            step(1'b0, '0);
        end
        check("t5_reached", 64'(hit), 64'(1));
        check("t5_flushed", 64'(bus.fifo_count), 64'(0));
        repeat (10) step(1'b0, '0);

        // Error response on one address; the stream continues.
        do_reset();
        set_knobs(100, 100, 0, 0, 0);
        err_addr = 32'h8000_0004;
        repeat (20) step(1'b0, '0);
        err_addr = 32'h1;

        // Long random run with a reset dropped in the middle of traffic.
        do_reset();
        set_knobs(70, 60, 3, 10, 3);
        repeat (1500) step(1'b0, '0);
        do_reset();
        set_knobs(70, 60, 3, 10, 3);
        repeat (1500) step(1'b0, '0);
        set_knobs(100, 100, 10, 5, 0);
        repeat (500) step(1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
